// File: rtl/if1_fetch_ctrl_pkg.sv
// Shared types for the IF1 fetch sequencer: FSM states, redirect kinds and
// the redirect record passed between the arbiter and the sequencer.
package if1_fetch_ctrl_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } fetch_state_e;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_EXC  = 2'd1,
      RD_EX   = 2'd2,
      RD_ID   = 2'd3
   } redirect_kind_e;

   typedef struct packed {
      logic           valid;
      redirect_kind_e kind;
      logic [31:0]    target;
   } redirect_t;

   // Larger rank wins; RD_NONE ranks below every real redirect.
   function automatic logic [1:0] kind_rank(input redirect_kind_e kind);
      case (kind)
         RD_EXC:  return 2'd3;
         RD_EX:   return 2'd2;
         RD_ID:   return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   // Exception and mispredict redirects load the corrected PC.
   function automatic logic kind_is_wrong(input redirect_kind_e kind);
      return (kind == RD_EXC) || (kind == RD_EX);
   endfunction

endpackage

// File: rtl/if1_fetch_ctrl_arb.sv
// Redirect arbiter: resolves same-cycle redirect pulses by priority and holds
// the winner until the sequencer applies it. The output is the merged view of
// the held redirect and this cycle's pulses, so a redirect can be applied in
// the same cycle it arrives.
module fetch_redirect_arb
   import if1_fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_redirect,
   input  logic [31:0] exc_target,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   input  logic        id_redirect,
   input  logic [31:0] id_target,
   input  logic        apply,
   output redirect_t   redir
);

   redirect_t incoming;
   redirect_t pending_q;
   redirect_t pending_d;

   // Pick the highest-priority pulse of this cycle.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      incoming = '0;
      if (exc_redirect) begin
         incoming = '{valid: 1'b1, kind: RD_EXC, target: exc_target};
      end else if (ex_redirect) begin
         incoming = '{valid: 1'b1, kind: RD_EX, target: ex_target};
      end else if (id_redirect) begin
         incoming = '{valid: 1'b1, kind: RD_ID, target: id_target};
      end
   end

   // A new pulse of equal or higher priority replaces the held redirect.
   always_comb begin
      redir = pending_q;
      if (incoming.valid && (kind_rank(incoming.kind) >= kind_rank(pending_q.kind))) begin
         redir = incoming;
      end
   end

   // Applying a redirect empties the hold register; otherwise keep the merged winner.
   always_comb begin
      pending_d = redir;
      if (apply) begin
         pending_d = '0;
      end
   end

   // Hold register for a redirect that could not be applied yet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/if1_fetch_ctrl.sv
// IF1 fetch sequencer: drives PC update strobes and selects, presents icache
// requests (address held stable until accepted), counts in-flight fetches and
// marks responses that belong to a path abandoned by a redirect.
module if1_fetch_ctrl
   import if1_fetch_ctrl_pkg::*;
#(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_redirect,
   input  logic [31:0] exc_target,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   input  logic        id_redirect,
   input  logic [31:0] id_target,
   input  logic        if_stall,
   input  logic        icache_addr_ok,
   input  logic        icache_data_ok,
   output logic        icache_req,
   output logic        pc_wen,
   output logic        pc_is_wrong,
   output logic [31:0] pc_correct,
   output logic        is_branch,
   output logic [31:0] branch_address,
   output logic        resp_discard,
   output logic        if_flush
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

   fetch_state_e     state_q;
   fetch_state_e     state_d;
   logic [CNT_W-1:0] outst_q;
   logic [CNT_W-1:0] outst_d;
   logic [CNT_W-1:0] discard_q;
   logic [CNT_W-1:0] discard_d;
   redirect_t        redir;
   logic             accept;
   logic             apply;
   logic             can_issue;

   fetch_redirect_arb u_arb (
      .clk          (clk),
      .rst          (rst),
      .exc_redirect (exc_redirect),
      .exc_target   (exc_target),
      .ex_redirect  (ex_redirect),
      .ex_target    (ex_target),
      .id_redirect  (id_redirect),
      .id_target    (id_target),
      .apply        (apply),
      .redir        (redir)
   );

   // While a request is presented its address (the PC) must not move, so a
   // redirect may only land in the cycle the icache accepts it.
   assign accept = (state_q == S_REQ) && icache_addr_ok;
   assign apply  = redir.valid && ((state_q == S_IDLE) || accept);

   // In-flight count: +1 on accept, -1 per response, clamped at zero.
   always_comb begin
      outst_d = outst_q;
      if (accept && !icache_data_ok) begin
         outst_d = outst_q + CNT_ONE;
      end else if (!accept && icache_data_ok && (outst_q != '0)) begin
         outst_d = outst_q - CNT_ONE;
      end
   end

   // Wrong-path count: a redirect condemns everything still in flight,
   // including a request accepted this same cycle.
   always_comb begin
      discard_d = discard_q;
      if (apply) begin
         discard_d = outst_d;
      end else if (icache_data_ok && (discard_q != '0)) begin
         discard_d = discard_q - CNT_ONE;
      end
   end

   // Next state and output decode; outputs are forced low during reset.
   always_comb begin
      can_issue      = !if_stall && (outst_d < CNT_MAX);
      state_d        = state_q;
      icache_req     = 1'b0;
      pc_wen         = 1'b0;
      pc_is_wrong    = 1'b0;
      pc_correct     = '0;
      is_branch      = 1'b0;
      branch_address = '0;
      resp_discard   = 1'b0;
      if_flush       = 1'b0;

      case (state_q)
         S_IDLE: if (can_issue) state_d = S_REQ;
         S_REQ:  if (accept)    state_d = can_issue ? S_REQ : S_IDLE;
         default:               state_d = S_IDLE;
      endcase

      if (!rst) begin
         icache_req   = (state_q == S_REQ);
         pc_wen       = apply || accept;
         if_flush     = apply;
         pc_is_wrong  = apply && kind_is_wrong(redir.kind);
         is_branch    = apply && (redir.kind == RD_ID);
         resp_discard = icache_data_ok && (discard_q != '0);
         if (pc_is_wrong) pc_correct     = redir.target;
         if (is_branch)   branch_address = redir.target;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         outst_q   <= '0;
         discard_q <= '0;
      end else begin
         state_q   <= state_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

endmodule

// File: tb/tb_if1_fetch_ctrl.sv
// Scoreboard bench for if1_fetch_ctrl. The reference model keeps the list of
// in-flight fetches as a queue of wrong-path flags plus the held redirect, and
// pushes expected request/PC-update/response outcomes; a monitor pops them as
// the DUT presents each event.
module tb_if1_fetch_ctrl;

   localparam int MAX_OUTST = 2;

   typedef struct {
      bit          wrong;
      bit          branch;
      logic [31:0] tgt;
   } pc_ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        exc_redirect = 1'b0, ex_redirect = 1'b0, id_redirect = 1'b0;
   logic [31:0] exc_target = '0, ex_target = '0, id_target = '0;
   logic        if_stall = 1'b0, icache_addr_ok = 1'b0, icache_data_ok = 1'b0;
   logic        icache_req, pc_wen, pc_is_wrong, is_branch, resp_discard, if_flush;
   logic [31:0] pc_correct, branch_address;

   // staged stimulus for the next cycle; redirect pulses self-clear
   bit          s_exc, s_ex, s_id, s_stall, s_aok, s_dok;
   logic [31:0] s_exct, s_ext, s_idt;

   // reference model state
   bit          busy;
   bit          inflight[$];
   int          pend_rank;
   logic [31:0] pend_tgt;

   // scoreboard queues
   bit          req_q[$];
   pc_ev_t      pc_q[$];
   bit          resp_q[$];
   bit          mon_en = 1'b0;

   int          n_tests = 0;
   int          n_fail  = 0;

   if1_fetch_ctrl #(.MAX_OUTST(MAX_OUTST), .CNT_W(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .exc_redirect   (exc_redirect),
      .exc_target     (exc_target),
      .ex_redirect    (ex_redirect),
      .ex_target      (ex_target),
      .id_redirect    (id_redirect),
      .id_target      (id_target),
      .if_stall       (if_stall),
      .icache_addr_ok (icache_addr_ok),
      .icache_data_ok (icache_data_ok),
      .icache_req     (icache_req),
      .pc_wen         (pc_wen),
      .pc_is_wrong    (pc_is_wrong),
      .pc_correct     (pc_correct),
      .is_branch      (is_branch),
      .branch_address (branch_address),
      .resp_discard   (resp_discard),
      .if_flush       (if_flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One cycle of the reference model, evaluated on the inputs just driven.
   task automatic model_cycle();
      int          r, er;
      logic [31:0] t, et;
      bit          acc, app;
      pc_ev_t      ev;
      r = 0;
      t = '0;
      if (exc_redirect)     begin r = 3; t = exc_target; end
      else if (ex_redirect) begin r = 2; t = ex_target;  end
      else if (id_redirect) begin r = 1; t = id_target;  end
      if (r > 0 && r >= pend_rank) begin er = r; et = t; end
      else begin er = pend_rank; et = pend_tgt; end

      req_q.push_back(busy);
      acc = busy && icache_addr_ok;
      app = (er > 0) && (!busy || acc);
      if (icache_data_ok) resp_q.push_back(inflight.pop_front());
      if (acc) inflight.push_back(1'b0);
      if (app) foreach (inflight[i]) inflight[i] = 1'b1;
      if (acc || app) begin
         ev.wrong  = app && (er >= 2);
         ev.branch = app && (er == 1);
         ev.tgt    = app ? et : 32'h0;
         pc_q.push_back(ev);
      end
      if (!busy || acc) busy = !if_stall && (inflight.size() < MAX_OUTST);
      pend_rank = app ? 0 : er;
      pend_tgt  = et;
   endtask

   // Drive staged inputs for n cycles, each starting at a falling edge.
   task automatic step(input int n);
      for (int c = 0; c < n; c++) begin
         exc_redirect   = s_exc;  exc_target = s_exct;
         ex_redirect    = s_ex;   ex_target  = s_ext;
         id_redirect    = s_id;   id_target  = s_idt;
         if_stall       = s_stall;
         icache_addr_ok = s_aok;
         icache_data_ok = s_dok && (inflight.size() > 0);
         s_exc = 1'b0; s_ex = 1'b0; s_id = 1'b0;
         model_cycle();
         @(negedge clk);
      end
   endtask

   task automatic drain_check();
      check("pc_events_left", pc_q.size(), 0);
      check("resp_events_left", resp_q.size(), 0);
   endtask

   // Assert reset between edges with hostile inputs, check outputs, release on a falling edge.
   task automatic reset_dut();
      mon_en = 1'b0;
      #3;
      rst = 1'b1;
      exc_redirect = 1'b1; icache_addr_ok = 1'b1; icache_data_ok = 1'b1;
      #1;
      check("rst_flags", {icache_req, pc_wen, pc_is_wrong, is_branch, resp_discard, if_flush}, 0);
      check("rst_pc_correct", pc_correct, 0);
      check("rst_branch_address", branch_address, 0);
      exc_redirect = 1'b0; icache_addr_ok = 1'b0; icache_data_ok = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      busy = 1'b0; pend_rank = 0; pend_tgt = '0;
      inflight.delete(); req_q.delete(); pc_q.delete(); resp_q.delete();
      mon_en = 1'b1;
   endtask

   // Monitor: compare DUT events against the expected queues, mid low phase.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            if (req_q.size() == 0) check("req_underrun", 1, 0);
            else check("icache_req", icache_req, req_q.pop_front());
            if (pc_wen) begin
               if (pc_q.size() == 0) check("pc_wen_unexpected", pc_wen, 0);
               else begin
                  pc_ev_t ev;
                  ev = pc_q.pop_front();
                  check("pc_is_wrong", pc_is_wrong, ev.wrong);
                  check("is_branch", is_branch, ev.branch);
                  check("if_flush", if_flush, ev.wrong | ev.branch);
                  if (ev.wrong)  check("pc_correct", pc_correct, ev.tgt);
                  if (ev.branch) check("branch_address", branch_address, ev.tgt);
               end
            end else begin
               check("selects_without_wen", {if_flush, pc_is_wrong, is_branch}, 0);
            end
            if (icache_data_ok) begin
               if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
               else check("resp_discard", resp_discard, resp_q.pop_front());
            end else begin
               check("resp_discard_idle", resp_discard, 0);
            end
         end
      end
   end

   initial begin
      reset_dut();

      // back-to-back accepts until two fetches are outstanding
      s_aok = 1'b1; step(6);
      // drain both responses; sequencer returns to presenting a request
      s_aok = 1'b0; s_dok = 1'b1; step(2); s_dok = 1'b0;
      // mispredict held while the request waits, applied on accept
      s_ex = 1'b1; s_ext = 32'h1c00_0100; step(3);
      s_aok = 1'b1; step(2);
      // exception with two in flight: both condemned, a fresh one is not
      s_aok = 1'b0; s_exc = 1'b1; s_exct = 32'h1c00_0008; step(1);
      s_dok = 1'b1; step(2); s_dok = 1'b0;
      s_aok = 1'b1; step(1);
      s_aok = 1'b0; s_dok = 1'b1; step(1); s_dok = 1'b0;
      // id and ex together: ex wins
      s_id = 1'b1; s_idt = 32'h1c00_0200; s_ex = 1'b1; s_ext = 32'h1c00_0300;
      s_aok = 1'b1; step(1);
      // held exception survives a later mispredict pulse
      s_aok = 1'b0; s_exc = 1'b1; s_exct = 32'h1c00_0400; step(1);
      s_ex = 1'b1; s_ext = 32'h1c00_0500; step(1);
      s_aok = 1'b1; step(2);
      // id-only redirect applied while idle
      s_aok = 1'b0; s_id = 1'b1; s_idt = 32'h1c00_0600; step(1);
      // stall: request held until accepted, then idle until stall drops
      s_stall = 1'b1; s_dok = 1'b1; step(3); s_dok = 1'b0;
      s_stall = 1'b0; step(1);
      s_stall = 1'b1; step(2);
      s_aok = 1'b1; step(1);
      s_aok = 1'b0; step(2);
      s_stall = 1'b0; step(1);
      s_dok = 1'b1; step(2); s_dok = 1'b0;
      drain_check();

      // reset while a request is presented with one fetch outstanding
      reset_dut();
      s_aok = 1'b1; step(2);
      s_aok = 1'b0; step(1);
      drain_check();
      reset_dut();
      s_aok = 1'b1; step(3);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         s_exc   = ($urandom_range(0, 11) == 0);
         s_ex    = ($urandom_range(0, 7) == 0);
         s_id    = ($urandom_range(0, 5) == 0);
         s_exct  = $urandom & 32'hffff_fffc;
         s_ext   = $urandom & 32'hffff_fffc;
         s_idt   = $urandom & 32'hffff_fffc;
         s_stall = ($urandom_range(0, 4) == 0);
         s_aok   = $urandom_range(0, 1);
         s_dok   = ($urandom_range(0, 2) != 0);
         step(1);
      end
      s_exc = 1'b0; s_ex = 1'b0; s_id = 1'b0; s_stall = 1'b0; s_aok = 1'b0; s_dok = 1'b1;
      step(4);
      drain_check();
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
